// File: rtl/pll_reconfig_master.sv
// Avalon-MM initiator that reprograms one PLL output counter through the reconfig core.
// Define PLLRCFG_PHASE_STEP_EN to add a phase-step write between the C-counter and start writes.
module pll_reconfig_master #(
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_cnt_sel,
  input  logic [7:0]  req_hi,
  input  logic [7:0]  req_lo,
  input  logic        req_odd,
  input  logic        req_bypass,
`ifdef PLLRCFG_PHASE_STEP_EN
  input  logic [15:0] req_phase_steps,
  input  logic        req_phase_up,
`endif
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [5:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        pll_locked
);

  localparam logic [5:0]  ADDR_MODE   = 6'h00;
  localparam logic [5:0]  ADDR_STATUS = 6'h01;
  localparam logic [5:0]  ADDR_START  = 6'h02;
  localparam logic [5:0]  ADDR_C      = 6'h05;
  localparam logic [5:0]  ADDR_PHASE  = 6'h06;
  localparam logic [7:0]  GAP_LAST    = 8'(POLL_GAP - 1);
  localparam logic [31:0] TO_LIMIT    = 32'(TIMEOUT);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_MODE,
    ST_WR_C,
`ifdef PLLRCFG_PHASE_STEP_EN
    ST_WR_PHASE,
`endif
    ST_WR_START,
    ST_GAP,
    ST_RD_STATUS,
    ST_WAIT_LOCK,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t      state_reg, state_next;
  logic        ready_reg;
  logic [31:0] c_word_reg, c_word_next;
`ifdef PLLRCFG_PHASE_STEP_EN
  logic [31:0] phase_word_reg, phase_word_next;
`endif
  logic [7:0]  gap_cnt_reg, gap_cnt_next;
  logic [31:0] to_cnt_reg, to_cnt_next;
  logic        lock_meta_reg, lock_sync_reg;
  logic [5:0]  addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic        rd_reg, rd_next;
  logic        wr_reg, wr_next;

  // Write-state parameters, shared by the common write handshake below.
  logic        wr_state;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  state_t      wr_after;
  logic        to_hit;
  logic        unused_readdata;

  assign unused_readdata = ^avm_readdata[31:1];
  assign to_hit          = (to_cnt_reg >= TO_LIMIT);

  assign req_ready     = ready_reg && (state_reg == ST_IDLE);
  assign busy          = (state_reg != ST_IDLE);
  assign done          = (state_reg == ST_DONE);
  assign err           = (state_reg == ST_ERR);
  assign avm_address   = addr_reg;
  assign avm_writedata = wdata_reg;
  assign avm_read      = rd_reg;
  assign avm_write     = wr_reg;

  always_comb begin
    state_next      = state_reg;
    c_word_next     = c_word_reg;
`ifdef PLLRCFG_PHASE_STEP_EN
    phase_word_next = phase_word_reg;
`endif
    gap_cnt_next    = gap_cnt_reg;
    to_cnt_next     = to_cnt_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    rd_next         = rd_reg;
    wr_next         = wr_reg;
    wr_state        = 1'b0;
    wr_addr         = ADDR_MODE;
    wr_data         = 32'd0;
    wr_after        = ST_IDLE;

    // Saturating so a stuck lock cannot wrap the counter back below the limit.
    if ((state_reg == ST_GAP || state_reg == ST_RD_STATUS || state_reg == ST_WAIT_LOCK) && !to_hit)
      to_cnt_next = to_cnt_reg + 32'd1;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          c_word_next     = {9'd0, req_cnt_sel, req_odd, req_bypass, req_hi, req_lo};
`ifdef PLLRCFG_PHASE_STEP_EN
          phase_word_next = {10'd0, req_phase_up, req_cnt_sel, req_phase_steps};
`endif
          state_next      = ST_WR_MODE;
        end
      end
      ST_WR_MODE: begin
        wr_state = 1'b1;
        wr_addr  = ADDR_MODE;
        wr_data  = 32'd1;
        wr_after = ST_WR_C;
      end
      ST_WR_C: begin
        wr_state = 1'b1;
        wr_addr  = ADDR_C;
        wr_data  = c_word_reg;
`ifdef PLLRCFG_PHASE_STEP_EN
        wr_after = (phase_word_reg[15:0] != 16'd0) ? ST_WR_PHASE : ST_WR_START;
`else
        wr_after = ST_WR_START;
`endif
      end
`ifdef PLLRCFG_PHASE_STEP_EN
      ST_WR_PHASE: begin
        wr_state = 1'b1;
        wr_addr  = ADDR_PHASE;
        wr_data  = phase_word_reg;
        wr_after = ST_WR_START;
      end
`endif
      ST_WR_START: begin
        wr_state = 1'b1;
        wr_addr  = ADDR_START;
        wr_data  = 32'd1;
        wr_after = ST_GAP;
      end
      ST_GAP: begin
        if (to_hit) begin
          state_next = ST_ERR;
        end else if (gap_cnt_reg == GAP_LAST) begin
          // Raise the read on the way out so the gap is exactly POLL_GAP idle cycles.
          gap_cnt_next = 8'd0;
          rd_next      = 1'b1;
          addr_next    = ADDR_STATUS;
          state_next   = ST_RD_STATUS;
        end else begin
          gap_cnt_next = gap_cnt_reg + 8'd1;
        end
      end
      ST_RD_STATUS: begin
        if (rd_reg && !avm_waitrequest) begin
          rd_next = 1'b0;
          if (avm_readdata[0])
            state_next = ST_WAIT_LOCK;
          else if (to_hit)
            state_next = ST_ERR;
          else
            state_next = ST_GAP;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_sync_reg)
          state_next = ST_DONE;
        else if (to_hit)
          state_next = ST_ERR;
      end
      ST_DONE:  state_next = ST_IDLE;
      ST_ERR:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    // A fresh strobe is only raised from a low strobe, which guarantees one idle
    // cycle between consecutive writes.
    if (wr_state) begin
      if (!wr_reg) begin
        wr_next    = 1'b1;
        addr_next  = wr_addr;
        wdata_next = wr_data;
      end else if (!avm_waitrequest) begin
        wr_next    = 1'b0;
        state_next = wr_after;
        if (state_reg == ST_WR_START) begin
          to_cnt_next  = 32'd0;
          gap_cnt_next = 8'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      ready_reg      <= 1'b0;
      c_word_reg     <= 32'd0;
`ifdef PLLRCFG_PHASE_STEP_EN
      phase_word_reg <= 32'd0;
`endif
      gap_cnt_reg    <= 8'd0;
      to_cnt_reg     <= 32'd0;
      lock_meta_reg  <= 1'b0;
      lock_sync_reg  <= 1'b0;
      addr_reg       <= 6'd0;
      wdata_reg      <= 32'd0;
      rd_reg         <= 1'b0;
      wr_reg         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ready_reg      <= 1'b1;
      c_word_reg     <= c_word_next;
`ifdef PLLRCFG_PHASE_STEP_EN
      phase_word_reg <= phase_word_next;
`endif
      gap_cnt_reg    <= gap_cnt_next;
      to_cnt_reg     <= to_cnt_next;
      lock_meta_reg  <= pll_locked;
      lock_sync_reg  <= lock_meta_reg;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      rd_reg         <= rd_next;
      wr_reg         <= wr_next;
    end
  end

endmodule
